// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - opcodes, sequencer states and operand-use helpers
package pipe_hazard_ctrl_pkg;

    localparam logic [3:0] OP_ADD    = 4'h0;
    localparam logic [3:0] OP_SUB    = 4'h1;
    localparam logic [3:0] OP_XOR    = 4'h2;
    localparam logic [3:0] OP_RED    = 4'h3;
    localparam logic [3:0] OP_SLL    = 4'h4;
    localparam logic [3:0] OP_SRA    = 4'h5;
    localparam logic [3:0] OP_ROR    = 4'h6;
    localparam logic [3:0] OP_PADDSB = 4'h7;
    localparam logic [3:0] OP_LW     = 4'h8;
    localparam logic [3:0] OP_SW     = 4'h9;
    localparam logic [3:0] OP_LLB    = 4'hA;
    localparam logic [3:0] OP_LHB    = 4'hB;
    localparam logic [3:0] OP_B      = 4'hC;
    localparam logic [3:0] OP_BR     = 4'hD;
    localparam logic [3:0] OP_PCS    = 4'hE;
    localparam logic [3:0] OP_HLT    = 4'hF;

    typedef enum logic [2:0] {
        ST_RUN    = 3'd0,
        ST_DFILL  = 3'd1,
        ST_IFILL  = 3'd2,
        ST_RESUME = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    // True when the opcode consumes the rs field
    function automatic logic reads_rs(input logic [3:0] op);
        return (op <= OP_LW) || (op == OP_SW) || (op == OP_BR);
    endfunction

    // True when the opcode consumes the rt field (R-type ALU only)
    function automatic logic reads_rt(input logic [3:0] op);
        return (op <= OP_RED) || (op == OP_PADDSB);
    endfunction

    // True when the opcode consumes the rd field (SW data, LLB/LHB merge)
    function automatic logic reads_rd(input logic [3:0] op);
        return (op == OP_SW) || (op == OP_LLB) || (op == OP_LHB);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fill_arbiter.sv
// rtl/pipe_hazard_ctrl_fill_arbiter.sv - fill port arbitration FSM with timeout watchdog
module pipe_hazard_ctrl_fill_arbiter
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int FILL_TIMEOUT = 64
) (
    input  logic   i_clk,
    input  logic   i_rst,
    input  logic   i_imiss,
    input  logic   i_dmiss,
    input  logic   i_fill_done,
    input  logic   i_halt_go,
    output state_t o_state,
    output logic   o_err_timeout
);

    localparam int TW = $clog2(FILL_TIMEOUT + 1);
    localparam logic [TW-1:0] TO_MAX  = TW'(FILL_TIMEOUT);
    localparam logic [TW-1:0] TO_LAST = TW'(FILL_TIMEOUT - 1);

    state_t        r_state;
    state_t        w_next;
    logic [TW-1:0] r_tcnt;
    logic          r_err;
    // Remembers which side the last fill served so RESUME does not re-fill it
    logic          r_last_d;
    logic          w_in_fill;

    assign w_in_fill     = (r_state == ST_DFILL) || (r_state == ST_IFILL);
    assign o_state       = r_state;
    assign o_err_timeout = r_err;

    // State register, fill watchdog and sticky timeout flag
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_RUN;
            r_tcnt   <= '0;
            r_err    <= 1'b0;
            r_last_d <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_in_fill) begin
                r_last_d <= (r_state == ST_DFILL);
                if (i_fill_done) begin
                    r_tcnt <= '0;
                end else if (r_tcnt != TO_MAX) begin
                    r_tcnt <= r_tcnt + 1'b1;
                    if (r_tcnt == TO_LAST) begin
                        r_err <= 1'b1;
                    end
                end
            end else begin
                r_tcnt <= '0;
            end
        end
    end

    // Next state: D-miss wins in RUN, fills never preempt, RESUME chains the other side
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_RUN: begin
                if (i_dmiss)        w_next = ST_DFILL;
                else if (i_imiss)   w_next = ST_IFILL;
                else if (i_halt_go) w_next = ST_HALT;
            end
            ST_DFILL, ST_IFILL: begin
                if (i_fill_done) w_next = ST_RESUME;
            end
            ST_RESUME: begin
                if (i_dmiss && !r_last_d)     w_next = ST_DFILL;
                else if (i_imiss && r_last_d) w_next = ST_IFILL;
                else                          w_next = ST_RUN;
            end
            ST_HALT: w_next = ST_HALT;
            default: w_next = ST_RUN;
        endcase
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall/flush/freeze sequencer top
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int FILL_TIMEOUT = 64,
    parameter int CNT_W        = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [15:0]      i_id_instr,
    input  logic             i_id_valid,
    input  logic             i_id_br_taken,
    input  logic             i_ex_regwrite,
    input  logic             i_ex_memtoreg,
    input  logic [3:0]       i_ex_dst,
    input  logic             i_ex_setflags,
    input  logic             i_mem_regwrite,
    input  logic [3:0]       i_mem_dst,
    input  logic             i_imiss,
    input  logic             i_dmiss,
    input  logic             i_fill_done,
    output logic             o_fill_req,
    output logic             o_fill_sel,
    output logic             o_pc_write,
    output logic             o_ifid_write,
    output logic             o_ifid_flush,
    output logic             o_idex_bubble,
    output logic             o_pipe_freeze,
    output logic             o_halted,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic             o_err_timeout
);

    state_t           w_state;
    logic [3:0]       w_op;
    logic [3:0]       w_rd;
    logic [3:0]       w_rs;
    logic [3:0]       w_rt;
    logic             w_rs_ex;
    logic             w_rt_ex;
    logic             w_rd_ex;
    logic             w_load_use;
    logic             w_flag_wait;
    logic             w_br_wait;
    logic             w_hazard;
    logic             w_halt_go;
    logic [CNT_W-1:0] r_stall_cnt;

    assign w_op = i_id_instr[15:12];
    assign w_rd = i_id_instr[11:8];
    assign w_rs = i_id_instr[7:4];
    assign w_rt = i_id_instr[3:0];

    // Register 0 is hardwired, so a zero destination never matches
    assign w_rs_ex = reads_rs(w_op) && (w_rs != 4'd0) && (w_rs == i_ex_dst);
    assign w_rt_ex = reads_rt(w_op) && (w_rt != 4'd0) && (w_rt == i_ex_dst);
    assign w_rd_ex = reads_rd(w_op) && (w_op != OP_SW) && (w_rd != 4'd0) && (w_rd == i_ex_dst);

    // SW store data is forwarded MEM-to-MEM, so only address/ALU operands wait on a load
    assign w_load_use  = i_ex_memtoreg && i_ex_regwrite && (w_rs_ex || w_rt_ex || w_rd_ex);
    assign w_flag_wait = ((w_op == OP_B) || (w_op == OP_BR)) && i_ex_setflags;
    // BR reads its target in ID where nothing is forwarded
    assign w_br_wait   = (w_op == OP_BR) && (w_rs != 4'd0) &&
                         ((i_ex_regwrite && (i_ex_dst == w_rs)) ||
                          (i_mem_regwrite && (i_mem_dst == w_rs)));

    assign w_hazard  = (w_state == ST_RUN) && i_id_valid && (w_load_use || w_flag_wait || w_br_wait);
    assign w_halt_go = (w_state == ST_RUN) && i_id_valid && (w_op == OP_HLT) && !w_hazard;

    pipe_hazard_ctrl_fill_arbiter #(
        .FILL_TIMEOUT(FILL_TIMEOUT)
    ) u_fill_arbiter (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_imiss      (i_imiss),
        .i_dmiss      (i_dmiss),
        .i_fill_done  (i_fill_done),
        .i_halt_go    (w_halt_go),
        .o_state      (w_state),
        .o_err_timeout(o_err_timeout)
    );

    // Control decode: freeze > I-fill > hazard stall > branch flush; freeze also holds ID/EX
    always_comb begin
        o_fill_req    = 1'b0;
        o_fill_sel    = 1'b0;
        o_pc_write    = 1'b1;
        o_ifid_write  = 1'b1;
        o_ifid_flush  = 1'b0;
        o_idex_bubble = 1'b0;
        o_pipe_freeze = 1'b0;
        o_halted      = 1'b0;
        case (w_state)
            ST_DFILL: begin
                o_fill_req    = 1'b1;
                o_fill_sel    = 1'b1;
                o_pc_write    = 1'b0;
                o_ifid_write  = 1'b0;
                o_pipe_freeze = 1'b1;
            end
            ST_RESUME: begin
                o_pc_write    = 1'b0;
                o_ifid_write  = 1'b0;
                o_pipe_freeze = 1'b1;
            end
            ST_IFILL: begin
                o_fill_req    = 1'b1;
                o_pc_write    = 1'b0;
                o_ifid_write  = 1'b0;
                o_idex_bubble = 1'b1;
            end
            ST_HALT: begin
                o_halted      = 1'b1;
                o_pc_write    = 1'b0;
                o_ifid_write  = 1'b0;
                o_idex_bubble = 1'b1;
            end
            default: begin
                if (w_hazard) begin
                    o_pc_write    = 1'b0;
                    o_ifid_write  = 1'b0;
                    o_idex_bubble = 1'b1;
                end else if (i_id_br_taken) begin
                    o_ifid_flush  = 1'b1;
                end
            end
        endcase
    end

    // Saturating count of PC-hold cycles, excluding the terminal HALT state
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stall_cnt <= '0;
        end else if (!o_pc_write && (w_state != ST_HALT) && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] id_instr;
    logic        id_valid, id_br_taken;
    logic        ex_regwrite, ex_memtoreg, ex_setflags, mem_regwrite;
    logic [3:0]  ex_dst, mem_dst;
    logic        imiss, dmiss, fill_done;
    logic        fill_req, fill_sel, pc_write, ifid_write, ifid_flush;
    logic        idex_bubble, pipe_freeze, halted, err_timeout;
    logic [15:0] stall_cnt;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.FILL_TIMEOUT(64), .CNT_W(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_id_instr(id_instr), .i_id_valid(id_valid),
        .i_id_br_taken(id_br_taken), .i_ex_regwrite(ex_regwrite), .i_ex_memtoreg(ex_memtoreg),
        .i_ex_dst(ex_dst), .i_ex_setflags(ex_setflags), .i_mem_regwrite(mem_regwrite),
        .i_mem_dst(mem_dst), .i_imiss(imiss), .i_dmiss(dmiss), .i_fill_done(fill_done),
        .o_fill_req(fill_req), .o_fill_sel(fill_sel), .o_pc_write(pc_write),
        .o_ifid_write(ifid_write), .o_ifid_flush(ifid_flush), .o_idex_bubble(idex_bubble),
        .o_pipe_freeze(pipe_freeze), .o_halted(halted), .o_stall_cnt(stall_cnt),
        .o_err_timeout(err_timeout)
    );

    // {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze, halted, fill_req, fill_sel, err}
    localparam logic [8:0] C_RUN    = 9'b110000000;
    localparam logic [8:0] C_STALL  = 9'b000100000;
    localparam logic [8:0] C_FLUSH  = 9'b111000000;
    localparam logic [8:0] C_DFILL  = 9'b000010110;
    localparam logic [8:0] C_RESUME = 9'b000010000;
    localparam logic [8:0] C_IFILL  = 9'b000100100;
    localparam logic [8:0] C_HALT   = 9'b000101000;

    typedef struct packed {
        logic [8:0]  ctl;
        logic [15:0] cnt;
    } vec_t;

    typedef struct {
        int    cyc;
        string nm;
        vec_t  v;
    } item_t;

    item_t       sbq[$];
    item_t       mit;
    vec_t        act;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [15:0] model_cnt = 16'd0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops every expectation due this cycle and compares mid-cycle
    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            mit = sbq.pop_front();
            act = {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze,
                   halted, fill_req, fill_sel, err_timeout, stall_cnt};
            n_tests++;
            if (mit.cyc != cyc || act !== mit.v) begin
                n_fail++;
                $display("FAIL %s: got ctl=%b cnt=%0d, expected ctl=%b cnt=%0d",
                         mit.nm, act.ctl, act.cnt, mit.v.ctl, mit.v.cnt);
            end
        end
    end

    task automatic step(input string nm, input logic [8:0] ctl);
        item_t it;
        it.cyc = cyc;
        it.nm  = nm;
        it.v   = {ctl, model_cnt};
        sbq.push_back(it);
        if (!ctl[8] && !ctl[3] && model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        id_instr = 16'h0000; id_valid = 0; id_br_taken = 0;
        ex_regwrite = 0; ex_memtoreg = 0; ex_dst = 0; ex_setflags = 0;
        mem_regwrite = 0; mem_dst = 0;
        imiss = 0; dmiss = 0; fill_done = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        model_cnt = 16'd0;
    endtask

    initial begin
        clear_in();
        do_reset();
        step("reset_idle", C_RUN);

        // Load-use on an ALU source
        ex_memtoreg = 1; ex_regwrite = 1; ex_dst = 4'd3;
        id_instr = 16'h0132; id_valid = 1;
        step("loaduse_add", C_STALL);
        ex_memtoreg = 0; ex_regwrite = 0; ex_dst = 0;
        step("loaduse_release", C_RUN);
        ex_memtoreg = 1; ex_regwrite = 1; ex_dst = 4'd3;
        id_instr = 16'h9340;
        step("sw_data_fwd", C_RUN);
        id_instr = 16'hA312;
        step("llb_rd_use", C_STALL);
        ex_dst = 4'd0; id_instr = 16'h0100;
        step("r0_no_hazard", C_RUN);
        clear_in();

        // Flag wait on B, then flush once flags settle
        ex_setflags = 1; id_instr = 16'hC000; id_valid = 1; id_br_taken = 1;
        step("b_flag_wait", C_STALL);
        ex_setflags = 0;
        step("b_taken_flush", C_FLUSH);
        clear_in();

        // BR register waits
        id_instr = 16'hD050; id_valid = 1; mem_regwrite = 1; mem_dst = 4'd5;
        step("br_mem_wait", C_STALL);
        mem_regwrite = 0;
        step("br_mem_clear", C_RUN);
        id_instr = 16'hD000; mem_regwrite = 1; mem_dst = 0; ex_regwrite = 1; ex_dst = 0;
        step("br_r0", C_RUN);
        id_instr = 16'hD050; mem_regwrite = 0; ex_dst = 4'd5; id_br_taken = 1;
        step("br_ex_wait_noflush", C_STALL);
        clear_in();

        // Simultaneous misses: D first, then I; D rising during IFILL waits
        imiss = 1; dmiss = 1;
        step("miss_run", C_RUN);
        step("dfill", C_DFILL);
        fill_done = 1;
        step("dfill_done", C_DFILL);
        fill_done = 0; dmiss = 0;
        step("resume_d", C_RESUME);
        dmiss = 1;
        step("ifill_no_preempt", C_IFILL);
        fill_done = 1;
        step("ifill_done", C_IFILL);
        fill_done = 0; imiss = 0;
        step("resume_i", C_RESUME);
        fill_done = 1;
        step("dfill_chained", C_DFILL);
        fill_done = 0; dmiss = 0;
        step("resume_last", C_RESUME);
        step("back_to_run", C_RUN);

        // HLT
        id_instr = 16'hF000; id_valid = 1;
        step("hlt_in_id", C_RUN);
        id_valid = 0;
        step("halted_1", C_HALT);
        imiss = 1;
        step("halted_2", C_HALT);
        step("halted_3", C_HALT);
        clear_in();

        // Fill timeout, sticky until reset
        do_reset();
        step("reset_idle2", C_RUN);
        dmiss = 1;
        step("to_enter", C_RUN);
        for (int i = 0; i < 64; i++) step("to_wait", C_DFILL);
        for (int i = 0; i < 3; i++) step("to_err", C_DFILL | 9'b000000001);
        do_reset();
        step("rst_clears_err", C_RUN);
        clear_in();

        @(posedge clk);
        #1;
        n_tests++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d pending, expected 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
